// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, funct codes,
// ALU operations and datapath select codes.
package mc_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXE    = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMX4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// R-type funct decoder: ALU operation plus a flag marking the funct as one the
// controller knows how to execute.
module alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] aluctrl,
    output logic       supported
);

    always_comb begin
        // NOTE: defaults on every path keep this block purely combinational (no latch).
        aluctrl   = ALU_ADD;
        supported = 1'b1;
        case (funct)
            FN_ADD:  aluctrl = ALU_ADD;
            FN_SUB:  aluctrl = ALU_SUB;
            FN_AND:  aluctrl = ALU_AND;
            FN_OR:   aluctrl = ALU_OR;
            FN_SLT:  aluctrl = ALU_SLT;
            default: supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS-subset control FSM: Moore outputs decoded from the registered
// state, with the opcode steering DECODE and MEMADR branching.
module mcycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcwe,
    output logic       irwe,
    output logic       memwe,
    output logic       iord,
    output logic       regwe,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluctrl,
    output logic [1:0] pcsrc,
    output logic [3:0] state
);

    logic [3:0] next_state;
    logic [2:0] fn_aluctrl;
    logic       fn_supported;

    alu_dec u_alu_dec (
        .funct     (funct),
        .aluctrl   (fn_aluctrl),
        .supported (fn_supported)
    );

    // NOTE: state is a flop, so it takes a non-blocking assignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = fn_supported ? S_EXE : S_FETCH;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXE:    next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // Unlisted states, including the unused encodings 13-15, fall through with all zeros.
    always_comb begin
        pcwe     = 1'b0;
        irwe     = 1'b0;
        memwe    = 1'b0;
        iord     = 1'b0;
        regwe    = 1'b0;
        regdst   = REGDST_RT;
        memtoreg = MTR_ALUOUT;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RT;
        aluctrl  = ALU_AND;
        pcsrc    = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                irwe    = 1'b1;
                pcwe    = 1'b1;
                alusrcb = SRCB_FOUR;
                aluctrl = ALU_ADD;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMX4;
                aluctrl = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluctrl = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwe    = 1'b1;
                regdst   = REGDST_RT;
                memtoreg = MTR_MDR;
            end
            S_MEMWR: begin
                iord  = 1'b1;
                memwe = 1'b1;
            end
            S_EXE: begin
                alusrca = 1'b1;
                alusrcb = SRCB_RT;
                aluctrl = fn_aluctrl;
            end
            S_ALUWB: begin
                regwe    = 1'b1;
                regdst   = REGDST_RD;
                memtoreg = MTR_ALUOUT;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                alusrcb = SRCB_RT;
                aluctrl = ALU_SUB;
                pcsrc   = PCSRC_ALUOUT;
                pcwe    = zero;
            end
            S_ADDIWB: begin
                regwe    = 1'b1;
                regdst   = REGDST_RT;
                memtoreg = MTR_ALUOUT;
            end
            S_JUMP: begin
                pcsrc = PCSRC_JUMP;
                pcwe  = 1'b1;
            end
            S_JAL: begin
                pcsrc    = PCSRC_JUMP;
                pcwe     = 1'b1;
                regwe    = 1'b1;
                regdst   = REGDST_RA;
                memtoreg = MTR_PC;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: walks each instruction class through its
// state sequence and checks the Moore controls in each state.
module tb_mcycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcwe, irwe, memwe, iord, regwe, alusrca;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] aluctrl;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mcycle_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .pcwe     (pcwe),
        .irwe     (irwe),
        .memwe    (memwe),
        .iord     (iord),
        .regwe    (regwe),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluctrl  (aluctrl),
        .pcsrc    (pcsrc),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge; also checks the write exclusivity.
    task automatic tick(input logic [3:0] exp_state);
        @(posedge clk);
        #1;
        check("state", {28'd0, state}, {28'd0, exp_state});
        check("regwe_memwe_excl", {31'd0, regwe & memwe}, 32'd0);
        check("irwe_only_fetch", {31'd0, irwe}, {31'd0, exp_state == 4'd0});
    endtask

    initial begin
        rst   = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        #12;
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_irwe", {31'd0, irwe}, 32'd1);
        check("rst_pcwe", {31'd0, pcwe}, 32'd1);
        check("rst_regwe", {31'd0, regwe}, 32'd0);
        check("rst_memwe", {31'd0, memwe}, 32'd0);
        rst = 1'b0;

        // lw: 0,1,2,3,4,0
        tick(4'd1);
        check("dec_alusrcb", {30'd0, alusrcb}, 32'h3);
        check("dec_aluctrl", {29'd0, aluctrl}, 32'h2);
        tick(4'd2);
        check("memadr_alusrca", {31'd0, alusrca}, 32'd1);
        check("memadr_alusrcb", {30'd0, alusrcb}, 32'h2);
        tick(4'd3);
        check("memrd_iord", {31'd0, iord}, 32'd1);
        check("memrd_regwe", {31'd0, regwe}, 32'd0);
        tick(4'd4);
        check("memwb_regwe", {31'd0, regwe}, 32'd1);
        check("memwb_memtoreg", {30'd0, memtoreg}, 32'h1);
        check("memwb_regdst", {30'd0, regdst}, 32'h0);
        tick(4'd0);
        check("lw_done_regwe", {31'd0, regwe}, 32'd0);

        // sw: 0,1,2,5,0
        op = 6'b101011;
        tick(4'd1);
        check("sw_dec_memwe", {31'd0, memwe}, 32'd0);
        tick(4'd2);
        check("sw_adr_memwe", {31'd0, memwe}, 32'd0);
        tick(4'd5);
        check("memwr_memwe", {31'd0, memwe}, 32'd1);
        check("memwr_iord", {31'd0, iord}, 32'd1);
        check("memwr_regwe", {31'd0, regwe}, 32'd0);
        tick(4'd0);
        check("sw_done_memwe", {31'd0, memwe}, 32'd0);

        // R-type slt
        op    = 6'b000000;
        funct = 6'b101010;
        tick(4'd1);
        tick(4'd6);
        check("exe_aluctrl_slt", {29'd0, aluctrl}, 32'h7);
        check("exe_alusrca", {31'd0, alusrca}, 32'd1);
        check("exe_alusrcb", {30'd0, alusrcb}, 32'h0);
        check("exe_regwe", {31'd0, regwe}, 32'd0);
        tick(4'd7);
        check("aluwb_regwe", {31'd0, regwe}, 32'd1);
        check("aluwb_regdst", {30'd0, regdst}, 32'h1);
        check("aluwb_memtoreg", {30'd0, memtoreg}, 32'h0);
        tick(4'd0);

        // R-type sub: a second funct decode
        funct = 6'b100010;
        tick(4'd1);
        tick(4'd6);
        check("exe_aluctrl_sub", {29'd0, aluctrl}, 32'h6);
        tick(4'd7);
        tick(4'd0);

        // R-type unsupported funct: 1 -> 0, no writes
        funct = 6'b000111;
        tick(4'd1);
        check("badfn_regwe", {31'd0, regwe}, 32'd0);
        tick(4'd0);
        check("badfn_memwe", {31'd0, memwe}, 32'd0);

        // beq taken
        op   = 6'b000100;
        zero = 1'b1;
        tick(4'd1);
        tick(4'd8);
        check("beq_t_pcwe", {31'd0, pcwe}, 32'd1);
        check("beq_t_pcsrc", {30'd0, pcsrc}, 32'h1);
        check("beq_t_aluctrl", {29'd0, aluctrl}, 32'h6);
        tick(4'd0);

        // beq not taken
        zero = 1'b0;
        tick(4'd1);
        tick(4'd8);
        check("beq_nt_pcwe", {31'd0, pcwe}, 32'd0);
        check("beq_nt_pcsrc", {30'd0, pcsrc}, 32'h1);
        tick(4'd0);

        // jal
        op = 6'b000011;
        tick(4'd1);
        tick(4'd12);
        check("jal_regwe", {31'd0, regwe}, 32'd1);
        check("jal_regdst", {30'd0, regdst}, 32'h2);
        check("jal_memtoreg", {30'd0, memtoreg}, 32'h2);
        check("jal_pcwe", {31'd0, pcwe}, 32'd1);
        check("jal_pcsrc", {30'd0, pcsrc}, 32'h2);
        tick(4'd0);

        // addi
        op = 6'b001000;
        tick(4'd1);
        tick(4'd9);
        check("addiex_alusrcb", {30'd0, alusrcb}, 32'h2);
        check("addiex_alusrca", {31'd0, alusrca}, 32'd1);
        tick(4'd10);
        check("addiwb_regwe", {31'd0, regwe}, 32'd1);
        check("addiwb_regdst", {30'd0, regdst}, 32'h0);
        check("addiwb_memtoreg", {30'd0, memtoreg}, 32'h0);
        tick(4'd0);

        // j
        op = 6'b000010;
        tick(4'd1);
        tick(4'd11);
        check("j_pcwe", {31'd0, pcwe}, 32'd1);
        check("j_pcsrc", {30'd0, pcsrc}, 32'h2);
        check("j_regwe", {31'd0, regwe}, 32'd0);
        tick(4'd0);

        // unknown opcode
        op = 6'b111111;
        tick(4'd1);
        tick(4'd0);

        // reset pulse in MEMWB aborts the lw
        op = 6'b100011;
        tick(4'd1);
        tick(4'd2);
        tick(4'd3);
        tick(4'd4);
        check("pre_rst_regwe", {31'd0, regwe}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_regwe", {31'd0, regwe}, 32'd0);
        check("async_rst_state", {28'd0, state}, 32'd0);
        check("async_rst_irwe", {31'd0, irwe}, 32'd1);
        #2;
        rst = 1'b0;
        tick(4'd1);
        tick(4'd2);
        tick(4'd3);
        tick(4'd4);
        check("post_rst_regwe", {31'd0, regwe}, 32'd1);
        tick(4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameters: none; all encodings are fixed constants held in the shared package.
REQ-002 clk  in  1  clock; state register advances on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 op  in  6  opcode from instruction register, bits [31:26].
REQ-005 funct  in  6  function field from instruction register, bits [5:0].
REQ-006 zero  in  1  ALU zero flag; sampled in BRANCH only.
REQ-007 pcwe  out  1  PC write enable.
REQ-008 irwe  out  1  instruction register write enable.
REQ-009 memwe  out  1  data memory write enable.
REQ-010 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 regwe  out  1  register-file write enable; the register file captures data on negedge, mid-state.
REQ-012 regdst  out  2  write-address select: 00 = rt, 01 = rd, 10 = 31.
REQ-013 memtoreg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-014 alusrca  out  1  ALU A select: 0 = PC, 1 = rs data.
REQ-015 alusrcb  out  2  ALU B select: 00 = rt data, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
REQ-016 aluctrl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-017 pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 state  out  4  current state, for debug.

Function
REQ-019 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12.
REQ-020 Outputs are Moore, decoded from the registered state only; any output not listed for a state is 0.
REQ-021 FETCH: irwe=1, pcwe=1, alusrcb=01, aluctrl=010; next state DECODE.
REQ-022 DECODE: alusrcb=11, aluctrl=010; next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) with supported funct -> EXE
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- 000011 (jal) -> JAL
- anything else -> FETCH
REQ-023 Supported funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. An R-type with any other funct returns to FETCH with no writes.
REQ-024 MEMADR: alusrca=1, alusrcb=10, aluctrl=010; next state MEMRD for lw, MEMWR for sw.
REQ-025 MEMRD: iord=1; next state MEMWB. MEMWB: regwe=1, regdst=00, memtoreg=01; next state FETCH.
REQ-026 MEMWR: iord=1, memwe=1; next state FETCH.
REQ-027 EXE: alusrca=1, alusrcb=00, aluctrl decoded from funct; next state ALUWB. ALUWB: regwe=1, regdst=01, memtoreg=00; next state FETCH.
REQ-028 BRANCH: alusrca=1, alusrcb=00, aluctrl=110, pcsrc=01, pcwe=zero; next state FETCH.
REQ-029 ADDIEX: same controls as MEMADR; next state ADDIWB. ADDIWB: regwe=1, regdst=00, memtoreg=00; next state FETCH.
REQ-030 JUMP: pcsrc=10, pcwe=1; next state FETCH. JAL: pcsrc=10, pcwe=1, regwe=1, regdst=10, memtoreg=10; next state FETCH.
REQ-031 Cycles per instruction, counted from entry to FETCH: lw 5; sw, R-type and addi 4; beq, j and jal 3; unsupported 2.
REQ-032 Undefined state encodings (13-15) go to FETCH on the next clock, with all outputs 0.
REQ-033 At most one of regwe and memwe is high in any state; irwe is high only in FETCH.

Reset
REQ-034 While rst=1, state is FETCH asynchronously and all outputs except the FETCH decode are 0.
REQ-035 Assertion of rst mid-instruction aborts it; no regwe or memwe is produced after rst rises.
REQ-036 The first posedge after rst falls moves FETCH to DECODE.

Structure
REQ-037 Shared package mc_pkg holds: state encodings, opcode and funct constants, aluctrl codes, and the select codes for regdst, memtoreg, alusrcb and pcsrc.
REQ-038 One sub-module, alu_dec, maps funct to aluctrl and provides a supported flag; it is purely combinational.

Verification
REQ-039 Reset then op=100011: states 0,1,2,3,4,0; regwe=1 only in state 4, with memtoreg=01 and regdst=00.
REQ-040 op=101011: states 0,1,2,5,0; memwe=1 and iord=1 only in state 5; regwe never asserted.
REQ-041 op=000000 with funct=101010: EXE gives aluctrl=111; ALUWB gives regdst=01. With funct=000111: 1 -> 0 and no writes.
REQ-042 op=000100: zero=1 gives pcwe=1 and pcsrc=01 in BRANCH; zero=0 gives pcwe=0.
REQ-043 op=000011: JAL gives regwe=1, regdst=10, memtoreg=10, pcwe=1; the next state is FETCH.
REQ-044 rst pulsed while in MEMWB: regwe drops immediately, state reads 0, and the next instruction fetch proceeds normally.
